// File: rtl/sysmgr_pll_ctrl.sv
// PLL reset/lock supervisor: holds the PLL in reset, waits for a stable lock, retries, then faults.
// Build option SYSMGR_PLL_CTRL_AUTORESTART_EN: a lock loss in RUN restarts the sequence instead of faulting.
module sysmgr_pll_ctrl #(
   parameter int HOLD_CYCLES   = 16,
   parameter int LOCK_TIMEOUT  = 1200,
   parameter int STABLE_CYCLES = 64,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       req_restart,
   output logic       pll_rst,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [3:0] loss_cnt
);

   // One counter serves as the hold timer in HOLD and the lock timeout in WAIT.
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   localparam int CW = (TW > HW) ? TW : HW;
   localparam int SW = $clog2(STABLE_CYCLES) + 1;

   typedef enum logic [1:0] {S_HOLD, S_WAIT, S_RUN, S_FAULT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic [SW-1:0] stab, stab_nxt, stab_inc;
   logic [3:0]    retry_nxt, loss_nxt;
   logic          sync0, lock_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync0  <= pll_lock;
         lock_s <= sync0;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stab_nxt  = stab;
      retry_nxt = retry_cnt;
      loss_nxt  = loss_cnt;
      cnt_inc   = cnt + CW'(1);
      stab_inc  = stab + SW'(1);

      unique case (state)
         S_HOLD: begin
            if (cnt_inc == CW'(HOLD_CYCLES)) begin
               state_nxt = S_WAIT;
               cnt_nxt   = '0;
               stab_nxt  = '0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         S_WAIT: begin
            cnt_nxt  = cnt_inc;
            stab_nxt = lock_s ? stab_inc : '0;
            // Transitions fire on the incremented value so WAIT lasts exactly the parameter count.
            if (lock_s && (stab_inc == SW'(STABLE_CYCLES))) begin
               state_nxt = S_RUN;
               retry_nxt = '0;
               cnt_nxt   = '0;
               stab_nxt  = '0;
            end else if (cnt_inc == CW'(LOCK_TIMEOUT)) begin
               retry_nxt = retry_cnt + 4'd1;
               cnt_nxt   = '0;
               stab_nxt  = '0;
               state_nxt = (retry_nxt == 4'(MAX_RETRY)) ? S_FAULT : S_HOLD;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               loss_nxt = (loss_cnt == 4'hF) ? loss_cnt : loss_cnt + 4'd1;
`ifdef SYSMGR_PLL_CTRL_AUTORESTART_EN
               state_nxt = S_HOLD;
               retry_nxt = '0;
`else
               state_nxt = S_FAULT;
`endif
            end
         end
         S_FAULT: begin
            state_nxt = S_FAULT;
         end
         default: begin
            state_nxt = S_HOLD;
         end
      endcase

      if (req_restart) begin
         state_nxt = S_HOLD;
         cnt_nxt   = '0;
         stab_nxt  = '0;
         retry_nxt = '0;
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HOLD;
         cnt       <= '0;
         stab      <= '0;
         retry_cnt <= '0;
         loss_cnt  <= '0;
         pll_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         stab      <= stab_nxt;
         retry_cnt <= retry_nxt;
         loss_cnt  <= loss_nxt;
         pll_rst   <= (state_nxt == S_HOLD) || (state_nxt == S_FAULT);
         ready     <= (state_nxt == S_RUN);
         fault     <= (state_nxt == S_FAULT);
      end
   end

endmodule

// File: tb/tb_sysmgr_pll_ctrl.sv
// Scoreboard bench for sysmgr_pll_ctrl: directed stimulus queues cycle-tagged expected outputs,
// a negedge monitor pops and compares them. Lock-loss expectations follow SYSMGR_PLL_CTRL_AUTORESTART_EN.
module tb_sysmgr_pll_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       req_restart;
   logic       pll_rst;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [3:0] loss_cnt;

   int unsigned cyc = 0;
   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      int unsigned due;
      string       name;
      logic        p;
      logic        r;
      logic        f;
      logic [3:0]  rc;
      logic [3:0]  lc;
   } exp_t;

   exp_t sb[$];

   sysmgr_pll_ctrl #(
      .HOLD_CYCLES  (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_lock   (pll_lock),
      .req_restart(req_restart),
      .pll_rst    (pll_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp(input int unsigned due, input string name, input logic p, input logic r,
                      input logic f, input logic [3:0] rc, input logic [3:0] lc);
      exp_t e;
      e.due = due; e.name = name; e.p = p; e.r = r; e.f = f; e.rc = rc; e.lc = lc;
      sb.push_back(e);
   endtask

   // Returns 1 after the posedge numbered n, with inputs driven 1 time unit later.
   task automatic wait_cyc(input int unsigned n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every expectation that falls due on this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         checks++;
         if (ready && fault) begin
            errors++;
            $display("FAIL ready_fault_exclusive cycle %0d: got ready=1 fault=1, want not both", cyc);
         end
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due != cyc) begin
               errors++;
               $display("FAIL %s: checked at cycle %0d, due at %0d", e.name, cyc, e.due);
            end else if ({pll_rst, ready, fault, retry_cnt, loss_cnt} !== {e.p, e.r, e.f, e.rc, e.lc}) begin
               errors++;
               $display("FAIL %s cycle %0d: got pll_rst=%b ready=%b fault=%b retry=%0d loss=%0d, want pll_rst=%b ready=%b fault=%b retry=%0d loss=%0d",
                        e.name, cyc, pll_rst, ready, fault, retry_cnt, loss_cnt, e.p, e.r, e.f, e.rc, e.lc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      pll_lock = 1'b0;
      req_restart = 1'b0;

      // Reset and nominal lock
      exp(1,  "reset_values",   1, 0, 0, 0, 0);
      exp(5,  "nom_hold_last",  1, 0, 0, 0, 0);
      exp(6,  "nom_wait",       0, 0, 0, 0, 0);
      exp(20, "nom_pre_ready",  0, 0, 0, 0, 0);
      exp(21, "nom_ready",      0, 1, 0, 0, 0);
      wait_cyc(2);  rst_n = 1'b1;
      wait_cyc(11); pll_lock = 1'b1;

      // Glitchy lock
      exp(25, "glitch_hold",      1, 0, 0, 0, 0);
      exp(28, "glitch_hold_last", 1, 0, 0, 0, 0);
      exp(29, "glitch_wait",      0, 0, 0, 0, 0);
      exp(46, "glitch_pre_ready", 0, 0, 0, 0, 0);
      exp(47, "glitch_ready",     0, 1, 0, 0, 0);
      wait_cyc(24); req_restart = 1'b1; pll_lock = 1'b0;
      wait_cyc(25); req_restart = 1'b0;
      wait_cyc(30); pll_lock = 1'b1;
      wait_cyc(36); pll_lock = 1'b0;
      wait_cyc(37); pll_lock = 1'b1;

      // Never locks
      exp(51,  "nolock_hold",      1, 0, 0, 0, 0);
      exp(55,  "nolock_wait1",     0, 0, 0, 0, 0);
      exp(74,  "nolock_wait1_end", 0, 0, 0, 0, 0);
      exp(75,  "nolock_retry1",    1, 0, 0, 1, 0);
      exp(78,  "nolock_hold2_end", 1, 0, 0, 1, 0);
      exp(79,  "nolock_wait2",     0, 0, 0, 1, 0);
      exp(98,  "nolock_wait2_end", 0, 0, 0, 1, 0);
      exp(99,  "nolock_fault",     1, 0, 1, 2, 0);
      exp(110, "nolock_fault_hold", 1, 0, 1, 2, 0);
      wait_cyc(50); req_restart = 1'b1; pll_lock = 1'b0;
      wait_cyc(51); req_restart = 1'b0;

      // Restart from FAULT with lock already high
      exp(111, "restart_hold",      1, 0, 0, 0, 0);
      exp(114, "restart_hold_last", 1, 0, 0, 0, 0);
      exp(115, "restart_wait",      0, 0, 0, 0, 0);
      exp(122, "restart_pre_ready", 0, 0, 0, 0, 0);
      exp(123, "restart_ready",     0, 1, 0, 0, 0);
      wait_cyc(105); pll_lock = 1'b1;
      wait_cyc(110); req_restart = 1'b1;
      wait_cyc(111); req_restart = 1'b0;

      // Lock loss in RUN
      exp(128, "loss_pre", 0, 1, 0, 0, 0);
`ifdef SYSMGR_PLL_CTRL_AUTORESTART_EN
      exp(129, "loss_to_hold",   1, 0, 0, 0, 1);
      exp(132, "loss_hold_last", 1, 0, 0, 0, 1);
      exp(133, "loss_wait",      0, 0, 0, 0, 1);
`else
      exp(129, "loss_to_fault",  1, 0, 1, 0, 1);
      exp(135, "loss_fault_hold", 1, 0, 1, 0, 1);
`endif
      wait_cyc(126); pll_lock = 1'b0;
      wait_cyc(129); pll_lock = 1'b1;

      // Async reset mid-WAIT, restart on the timeout cycle, stable/timeout tie
      exp(144, "rst_pre_wait",         0, 0, 0, 0, 1);
      exp(145, "rst_async",            1, 0, 0, 0, 0);
      exp(150, "rst_hold_last",        1, 0, 0, 0, 0);
      exp(151, "rst_wait",             0, 0, 0, 0, 0);
      exp(170, "tmo_pre",              0, 0, 0, 0, 0);
      exp(171, "tmo_restart_override", 1, 0, 0, 0, 0);
      exp(175, "tie_wait",             0, 0, 0, 0, 0);
      exp(194, "tie_pre",              0, 0, 0, 0, 0);
      exp(195, "tie_stable_wins",      0, 1, 0, 0, 0);
      wait_cyc(136); req_restart = 1'b1; pll_lock = 1'b0;
      wait_cyc(137); req_restart = 1'b0;
      wait_cyc(145); rst_n = 1'b0;
      wait_cyc(147); rst_n = 1'b1;
      wait_cyc(170); req_restart = 1'b1;
      wait_cyc(171); req_restart = 1'b0;
      wait_cyc(185); pll_lock = 1'b1;

      wait_cyc(200);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysmgr_pll_ctrl.md
# sysmgr_pll_ctrl

Supervisor that drives the PLL reset request of the system clock generator and monitors its lock output. It holds the PLL in reset for a defined time, waits for a stable lock, retries on timeout, and declares a fault after repeated failures. It runs from the raw 12 MHz board clock, ahead of the PLL, and is the requesting end of the clock generator's reset/lock interface.

## Interface
- `HOLD_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1 µs at 12 MHz).
- `LOCK_TIMEOUT`, 1200: cycles allowed in WAIT before the attempt fails (100 µs).
- `STABLE_CYCLES`, 64: consecutive synchronized lock-high samples required before RUN.
- `MAX_RETRY`, 3: consecutive failed attempts before FAULT (1..15).

- `clk` in 1: 12 MHz board clock, the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_lock` in 1: PLL lock, asynchronous to `clk`.
- `req_restart` in 1: single-cycle restart request, synchronous to `clk`.
- `pll_rst` out 1: active-high PLL reset request, connected to the clock generator's `rst_in`.
- `ready` out 1: PLL locked and stable.
- `fault` out 1: retry budget exhausted.
- `retry_cnt` out 4: consecutive failed attempts in the current sequence.
- `loss_cnt` out 4: lock losses seen in RUN; saturates at 15.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. No other path uses raw `pll_lock`.
- States are HOLD, WAIT, RUN and FAULT. All outputs are registered.
- **HOLD**: `pll_rst`=1 and the counter increments. After HOLD_CYCLES cycles, go to WAIT and clear both counters.
- **WAIT**: `pll_rst`=0.
  - The timeout counter increments every cycle.
  - The stable counter increments while `lock_s`=1 and clears to 0 on any `lock_s`=0 sample.
  - When the stable counter reaches STABLE_CYCLES, go to RUN and set `retry_cnt` to 0.
  - Otherwise, when the timeout counter reaches LOCK_TIMEOUT, increment `retry_cnt`. If the new value equals MAX_RETRY, go to FAULT; otherwise go to HOLD.
  - If stable and timeout complete in the same cycle, stable wins.
- **RUN**: `ready`=1. When `lock_s`=0, increment `loss_cnt` (saturating) and take the loss action defined under Configuration.
- **FAULT**: `pll_rst`=1, `fault`=1, `ready`=0. The only exit is `req_restart`.
- `req_restart`=1 in any state: the next state is HOLD, the counters and `retry_cnt` clear, and `loss_cnt` is kept. It overrides every other transition in the same cycle.
- Counter widths are sized with $clog2 of each parameter plus 1. The counters never wrap.

## Timing
- Reset values: state HOLD, `pll_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `loss_cnt`=0, synchronizer flops 0.
- `pll_rst` is high for exactly HOLD_CYCLES `clk` cycles per HOLD entry, counted from the first rising edge after reset release or after the transition into HOLD.
- Lock latency is 2 cycles through the synchronizer. `ready` rises 2+STABLE_CYCLES cycles after `pll_lock` rises in WAIT, provided it stays high.
- `ready` falls on the same edge as the state leaves RUN. That is 3 cycles after `pll_lock` falls: 2 synchronizer cycles plus the registered transition.
- `ready` and `fault` are never 1 together.
- When `rst_n` is asserted mid-sequence, all outputs go immediately to their reset values. This is asynchronous.

## Configuration
- `SYSMGR_PLL_CTRL_AUTORESTART_EN` defined: a lock loss in RUN goes to HOLD and starts a new sequence with `retry_cnt`=0.
- `SYSMGR_PLL_CTRL_AUTORESTART_EN` undefined: a lock loss in RUN goes straight to FAULT and `retry_cnt` is unchanged. Recovery needs `req_restart` or `rst_n`.
- In both builds, `loss_cnt` increments on a lock loss.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- **Nominal lock**: release `rst_n`, then raise `pll_lock` 5 cycles after `pll_rst` falls → `pll_rst` high for 4 cycles; `ready`=1 exactly 10 cycles after `pll_lock` rises; `retry_cnt`=0.
- **Glitchy lock**: in WAIT, lock high for 6 cycles, low for 1, then high → stable count restarts; `ready` rises 10 cycles after the final rise.
- **Never locks**: `pll_lock`=0 throughout → two HOLD/WAIT sequences of 4+20 cycles each; `retry_cnt` goes 1 then 2; `fault`=1 and `pll_rst`=1 thereafter.
- **Restart from FAULT**: pulse `req_restart` while in FAULT with `pll_lock`=1 → `fault`=0 and `pll_rst`=1 for 4 cycles; `retry_cnt`=0; `ready` rises after WAIT.
- **Lock loss in RUN**: drop `pll_lock` for 3 cycles → `ready`=0 3 cycles later and `loss_cnt`=1. With the macro, a new HOLD begins; without it, `fault`=1.
- **Reset mid-WAIT and simultaneous events**: assert `rst_n`=0 during WAIT → outputs reset immediately. Apply `req_restart` on the timeout cycle → the next state is HOLD and `retry_cnt`=0, not incremented.
